loom_dpi_scheduler: RTL
=======================

# loom_dpi_scheduler

Serializes DPI calls from the DUT bridge cells into the per-function DPI register file so that at most one call is outstanding at any time. Requesters are arbitrated round-robin. The scheduler tracks the active call until its return handshake completes, and exposes the active function index, a call-issued interrupt pulse and a watchdog timeout to the host-side control logic. It sits between the bridge cells' call/return ports and the regfile's `dpi_call_*` / `dpi_ret_*` ports.

## Interface

**Parameters**
- `N_FUNCS`, default 4: number of DPI functions, 1..1024.
- `TIMEOUT_W`, default 16: width of the watchdog counter and its limit.
- `CNT_W`, default 32: width of the completed-call counter.

**Ports**
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  allow new grants. Has no effect on a call already issued.
- `req_valid_i`  in  N_FUNCS  bridge call request, one bit per function.
- `req_ready_o`  out  N_FUNCS  bridge call accepted.
- `fwd_valid_o`  out  N_FUNCS  call_valid to the regfile.
- `fwd_ready_i`  in  N_FUNCS  call_ready from the regfile.
- `ret_done_i`  in  N_FUNCS  return handshake (ret_valid & ret_ready) for each function.
- `timeout_lim_i`  in  TIMEOUT_W  watchdog limit in cycles. 0 disables the watchdog.
- `timeout_clr_i`  in  1  clears the sticky timeout flag.
- `busy_o`  out  1  a call is granted or outstanding.
- `active_valid_o`  out  1  `active_idx_o` is meaningful.
- `active_idx_o`  out  $clog2(N_FUNCS) (minimum 1)  function currently granted or outstanding.
- `irq_o`  out  1  one-cycle pulse when a call is handed to the regfile.
- `timeout_o`  out  1  sticky flag: the outstanding call exceeded the limit.
- `call_count_o`  out  CNT_W  number of completed calls. Wraps modulo 2^CNT_W.

## Operation

**FSM states:** IDLE, ISSUE, WAIT.

**IDLE**
- When `enable_i=1` and `req_valid_i` is nonzero, select the first set bit at or after `rr_ptr`, searching circularly.
- Register the selection into `idx_q` and move to ISSUE.
- No outputs are asserted in IDLE.

**ISSUE**
- `fwd_valid_o[idx_q] = req_valid_i[idx_q]`. All other bits of `fwd_valid_o` are 0.
- `req_ready_o[idx_q] = fwd_ready_i[idx_q]`. All other bits of `req_ready_o` are 0.
- On a handshake (`req_valid_i[idx_q] & fwd_ready_i[idx_q]`):
  - pulse `irq_o` in the following cycle;
  - clear the watchdog counter;
  - move to WAIT.
- If `req_valid_i[idx_q]` drops before the handshake (request withdrawn), return to IDLE. `rr_ptr` is unchanged and no IRQ is raised.

**WAIT**
- `fwd_valid_o` and `req_ready_o` are all 0.
- The watchdog counter increments every cycle and saturates at its maximum value.
- When `timeout_lim_i != 0` and the counter equals `timeout_lim_i`, set `timeout_o`. The FSM stays in WAIT; the call is never aborted.
- On `ret_done_i[idx_q]`:
  - `call_count_o += 1`;
  - `rr_ptr = idx_q + 1`, wrapping to 0 when `idx_q = N_FUNCS-1`;
  - move to IDLE.
- `ret_done_i` bits other than `idx_q` are ignored, in every state.

**Status outputs**
- `busy_o` and `active_valid_o` are 1 in ISSUE and WAIT.
- `active_idx_o` = `idx_q`. It holds its last value in IDLE.
- `timeout_o` is cleared by `timeout_clr_i` only. If set and clear occur in the same cycle, set wins.
- Deasserting `enable_i` in ISSUE or WAIT does not cancel the call.

## Timing

**Reset values:** every output is 0 (`req_ready_o`, `fwd_valid_o`, `busy_o`, `active_valid_o`, `active_idx_o`, `irq_o`, `timeout_o`, `call_count_o`). State is IDLE, `rr_ptr=0`, watchdog counter 0. Reset asserted mid-call drops `fwd_valid_o` and `busy_o` immediately, without waiting for a clock edge.

**Latency and throughput**
- Request at cycle 0 in IDLE → ISSUE at cycle 1, with `fwd_valid_o` asserted at cycle 1.
- Regfile ready at cycle 1 → WAIT at cycle 2, with `irq_o=1` during cycle 2 only.
- `ret_done_i` at cycle k → IDLE at k+1, updated `call_count_o` visible at k+1.
- Earliest next ISSUE is k+2. Maximum throughput is one call per 3 cycles.

**Watchdog**
- The counter is 0 in the first WAIT cycle.
- `timeout_o` rises the cycle after the counter reaches `timeout_lim_i`, i.e. `timeout_lim_i + 1` cycles after entering WAIT.

**Combinational paths:** `fwd_valid_o` and `req_ready_o` are combinational from `req_valid_i` and `fwd_ready_i`. All other outputs are registered.

## Test plan

1. **Reset.** Assert `rst_ni=0` mid-WAIT → all outputs 0 asynchronously. After release with `req_valid_i=0001`, `fwd_valid_o=0001` exactly one cycle later.
2. **Single call.** N_FUNCS=4, `req_valid_i=0100`, `fwd_ready_i=1111`, `ret_done_i[2]` pulsed 10 cycles later → one `irq_o` pulse, `active_idx_o=2` throughout, `call_count_o=1`, `busy_o` falls the cycle after `ret_done_i`.
3. **Round-robin.** Hold `req_valid_i=1111` and return each call after 3 cycles → grant order 0,1,2,3,0,… with no repeats while other functions request. `call_count_o=8` after 8 returns.
4. **Regfile backpressure and withdrawal.**
   - `fwd_ready_i[1]=0` for 5 cycles → `fwd_valid_o[1]` held, `req_ready_o[1]=0`, no IRQ.
   - Dropping `req_valid_i[1]` while blocked → IDLE, the next grant starts from the same `rr_ptr`, and `call_count_o` is unchanged.
5. **Watchdog.**
   - `timeout_lim_i=20` with no return → `timeout_o=1` 21 cycles after entering WAIT; the FSM stays in WAIT.
   - `timeout_clr_i` pulse → `timeout_o=0`.
   - `timeout_lim_i=0` with 1000 idle cycles → `timeout_o` stays 0.
6. **Enable and spurious returns.**
   - `enable_i=0` with requests pending → no grant.
   - `enable_i` toggled low during WAIT → the call completes normally.
   - `ret_done_i[3]` pulsed while function 1 is active → ignored; state and `call_count_o` unchanged.

Source files
------------

// File: rtl/loom_dpi_scheduler.sv
// loom_dpi_scheduler: serializes DPI calls from the bridge cells into the
// per-function DPI register file. One call is outstanding at a time;
// requesters are picked round-robin, the active call is tracked until its
// return handshake, and a watchdog flags calls that run past a host limit.
module loom_dpi_scheduler #(
    parameter int N_FUNCS   = 4,
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 32,
    localparam int IDX_W    = (N_FUNCS > 1) ? $clog2(N_FUNCS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [N_FUNCS-1:0]   req_valid_i,
    output logic [N_FUNCS-1:0]   req_ready_o,
    output logic [N_FUNCS-1:0]   fwd_valid_o,
    input  logic [N_FUNCS-1:0]   fwd_ready_i,
    input  logic [N_FUNCS-1:0]   ret_done_i,
    input  logic [TIMEOUT_W-1:0] timeout_lim_i,
    input  logic                 timeout_clr_i,
    output logic                 busy_o,
    output logic                 active_valid_o,
    output logic [IDX_W-1:0]     active_idx_o,
    output logic                 irq_o,
    output logic                 timeout_o,
    output logic [CNT_W-1:0]     call_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic                 irq_q;
    logic                 timeout_q;
    logic [CNT_W-1:0]     count_q;

    logic [N_FUNCS-1:0]   high_req;
    logic [N_FUNCS-1:0]   pick_vec;
    logic [IDX_W-1:0]     sel_idx;
    logic                 handshake;
    logic                 ret_sel;
    logic                 timeout_set;

    // Round-robin pick: prefer requesters at or above rr_ptr, else wrap to the lowest.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        high_req = '0;
        sel_idx  = '0;
        for (int i = 0; i < N_FUNCS; i++) begin
            high_req[i] = req_valid_i[i] && (i >= int'(rr_ptr_q));
        end
        pick_vec = (|high_req) ? high_req : req_valid_i;
        for (int i = N_FUNCS - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign ret_sel     = ret_done_i[idx_q] && (state_q == S_WAIT);
    assign timeout_set = (state_q == S_WAIT) && (timeout_lim_i != '0) &&
                         (wd_cnt_q == timeout_lim_i);

    // Next-state logic plus the combinational call/ready forwarding in ISSUE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fwd_valid_o = '0;
        req_ready_o = '0;
        handshake   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable_i && (|req_valid_i)) begin
                    idx_d   = sel_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fwd_valid_o[idx_q] = req_valid_i[idx_q];
                req_ready_o[idx_q] = fwd_ready_i[idx_q];
                if (!req_valid_i[idx_q]) begin
                    state_d = S_IDLE;
                end else if (fwd_ready_i[idx_q]) begin
                    handshake = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ret_sel) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and granted index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Round-robin pointer advances past a function only once its call completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (ret_sel) begin
            rr_ptr_q <= (idx_q == IDX_W'(N_FUNCS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Watchdog: cleared on issue, saturating count while waiting for the return.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else if (handshake) begin
            wd_cnt_q <= '0;
        end else if (state_q == S_WAIT && wd_cnt_q != '1) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // Sticky timeout flag; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (timeout_set) begin
            timeout_q <= 1'b1;
        end else if (timeout_clr_i) begin
            timeout_q <= 1'b0;
        end
    end

    // Issue interrupt pulse and completed-call counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q   <= 1'b0;
            count_q <= '0;
        end else begin
            irq_q <= handshake;
            if (ret_sel) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign active_valid_o = (state_q != S_IDLE);
    assign active_idx_o   = idx_q;
    assign irq_o          = irq_q;
    assign timeout_o      = timeout_q;
    assign call_count_o   = count_q;

endmodule
